la_ram_write_arbiter: RTL and testbench
=======================================

# la_ram_write_arbiter

- Drains the capture FIFOs of both logic pods into DDR by issuing write bursts to the memory controller's native application port.
- It is the consumer end of the per-pod address/data FIFO read ports that each pod datapath exports toward the top-level DDR arbiter.
- Arbitrates round-robin between pod 0 and pod 1, one full burst at a time.
- Runs entirely in the clk_ram_2x domain.

## Interface
Parameters:
- BURST_LEN, 4: 128-bit data words written per address-FIFO entry (1..255).
- ADDR_WIDTH, 29: width of the address FIFO entries and of app_addr.

Ports:
- clk_ram_2x  in  1  sole clock.
- trig_rst_arbiter_2x  in  1  synchronous, active-high reset.
- ram_ready  in  1  memory controller calibrated; no new burst starts while low.
- la0_ram_addr_rd_en  out  1  pop pod 0 address FIFO.
- la0_ram_addr_rd_data  in  ADDR_WIDTH  pod 0 burst start address; valid 1 cycle after pop.
- la0_ram_addr_rd_size  in  8  pod 0 address FIFO occupancy.
- la0_ram_data_rd_en  out  1  pop pod 0 data FIFO.
- la0_ram_data_rd_data  in  128  pod 0 data word; valid 1 cycle after pop.
- la0_ram_data_rd_size  in  10  pod 0 data FIFO occupancy.
- la1_*: same seven ports for pod 1.
- app_en  out  1  command valid.
- app_cmd  out  3  fixed 3'b000 (write).
- app_addr  out  ADDR_WIDTH  burst address.
- app_rdy  in  1  command accepted when app_en && app_rdy.
- app_wdf_data  out  128  write data.
- app_wdf_wren  out  1  write data valid.
- app_wdf_end  out  1  high on the last word of the burst.
- app_wdf_rdy  in  1  data accepted when app_wdf_wren && app_wdf_rdy.
- busy  out  1  state != IDLE.
- la0_burst_count  out  32  completed pod 0 bursts; wraps.
- la1_burst_count  out  32  completed pod 1 bursts; wraps.

## Operation
**Eligibility**
- A pod is eligible when all of the following hold: addr_rd_size != 0, data_rd_size >= BURST_LEN, and ram_ready.

**Arbitration**
- prio bit, reset 0.
- In IDLE, if both pods are eligible, pick pod prio.
- Otherwise pick whichever pod is eligible.
- On burst completion, prio <= ~granted pod.

**State machine** (IDLE, ADDR_POP, ADDR_WAIT, CMD, DATA)
- IDLE → ADDR_POP when any pod is eligible; latch grant.
- ADDR_POP: one-cycle addr_rd_en for the granted pod → ADDR_WAIT.
- ADDR_WAIT: latch addr_rd_data into app_addr → CMD.
- CMD: app_en held high until app_rdy. The data pipeline may begin popping in CMD. On acceptance → DATA, or → IDLE if all BURST_LEN words were already accepted.
- DATA: remaining words streamed → IDLE on acceptance of the word with app_wdf_end.

**Data pipeline**
- Data pops for the granted pod only.
- A 2-entry skid buffer absorbs the 1-cycle FIFO read latency and app_wdf_rdy stalls.
- A pop is allowed when (skid occupancy + pops in flight) < 2 and popped < BURST_LEN.
- Sustains 1 word/cycle while app_wdf_rdy stays high.
- Words are presented strictly in pop order.
- app_wdf_end = (accepted_count == BURST_LEN-1) && app_wdf_wren.
- Write data may be accepted before the command; the controller permits this.

**Counters and errors**
- Burst counter of the granted pod increments on the cycle the last word is accepted.
- Eligibility is only evaluated in IDLE. ram_ready falling mid-burst does not abort the burst.
- FIFO underflow cannot occur by construction: eligibility guarantees BURST_LEN words are present.

## Timing
- Reset: every output is 0 (app_cmd 3'b000), prio=0, skid empty, counters 0, state IDLE.
- Reset asserted mid-burst: all of the above is restored on the next edge. The partial burst is abandoned and the FIFOs are not repopped.
- Minimum burst, with app_rdy and app_wdf_rdy always high and eligibility seen in IDLE at cycle 0:
  - addr_rd_en at 1; app_en at 3, accepted at 3.
  - First data pop at 3, first wren at 4.
  - Last word (wdf_end) at 3+BURST_LEN; return to IDLE at 4+BURST_LEN.
- Minimum gap between bursts: 1 IDLE cycle.
- rd_en strobes are single-cycle and never asserted for the non-granted pod.

## Structure
- Package la_ram_pkg: state enum, APP_CMD_WRITE = 3'b000, pod index typedef.
- Sub-module la_write_skid: 2-entry, 128-bit, valid/ready FIFO.
  - Ports: push, push_data, pop_ready, out_valid, out_data, count.
  - Instantiated once; the mux selects the granted pod's rd_data into it.

## Test plan
- Single pod: la0 addr_size=1, data_size=4, addr=29'h100, BURST_LEN=4, rdy always 1.
  - Expect: one app_en with app_addr=29'h100; 4 wren cycles in order; wdf_end on the 4th; la0_burst_count=1; la1 rd_en never asserted.
- Both pods eligible continuously, 3 entries each.
  - Expect grants la0, la1, la0, la1, la0, la1; counts 3/3.
- app_wdf_rdy toggles 1,0,1,0 during DATA.
  - Expect no word lost or duplicated; exactly 4 pops; data order preserved.
- app_rdy held low 10 cycles in CMD.
  - Expect app_en and app_addr stable throughout.
  - Expect data pops to halt at 2 until skid space frees, then the burst completes.
- Eligibility boundaries:
  - la0 data_size=3 with BURST_LEN=4 → no grant.
  - ram_ready=0 with pods eligible → no grant.
  - ram_ready dropped mid-burst → burst completes.
- trig_rst_arbiter_2x pulsed after 2 words of a burst.
  - Expect all outputs 0 next cycle, state IDLE, counters 0, prio 0.

Source files
------------

// File: rtl/la_ram_write_arbiter_pkg.sv
// Shared types and constants for the pod-to-DDR write arbiter.
package la_ram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_POP,
    ST_ADDR_WAIT,
    ST_CMD,
    ST_DATA
  } state_t;

  typedef logic pod_t;

  localparam pod_t POD0 = 1'b0;
  localparam pod_t POD1 = 1'b1;

  localparam logic [2:0] APP_CMD_WRITE = 3'b000;

endpackage

// File: rtl/la_ram_write_arbiter_if.sv
// Memory controller native application port (command + write data channels).
interface la_ram_write_arbiter_if #(
  parameter int ADDR_WIDTH = 29
);
  logic                  app_en;
  logic [2:0]            app_cmd;
  logic [ADDR_WIDTH-1:0] app_addr;
  logic                  app_rdy;
  logic [127:0]          app_wdf_data;
  logic                  app_wdf_wren;
  logic                  app_wdf_end;
  logic                  app_wdf_rdy;

  modport master (
    output app_en, app_cmd, app_addr, app_wdf_data, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy
  );

  modport slave (
    input  app_en, app_cmd, app_addr, app_wdf_data, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy
  );
endinterface

// File: rtl/la_ram_write_arbiter_skid.sv
// Two-entry fall-through FIFO: an empty buffer forwards the pushed word combinationally.
module la_write_skid (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [127:0] push_data,
  input  logic         pop_ready,
  output logic         out_valid,
  output logic [127:0] out_data,
  output logic [1:0]   count
);
  logic [127:0] r_mem [2];
  logic         r_wr;
  logic         r_rd;
  logic [1:0]   r_count;
  logic         w_empty;
  logic         w_store;
  logic         w_deq;

  assign w_empty   = (r_count == 2'd0);
  assign out_valid = !w_empty || push;
  assign out_data  = !w_empty ? r_mem[r_rd] : (push ? push_data : '0);
  assign count     = r_count;

  // A push bypasses storage only when the buffer is empty and the word leaves now.
  assign w_store = push && !(w_empty && pop_ready);
  assign w_deq   = out_valid && pop_ready && !w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_store) begin
        r_mem[r_wr] <= push_data;
        r_wr        <= ~r_wr;
      end
      if (w_deq) begin
        r_rd <= ~r_rd;
      end
      r_count <= r_count + 2'(w_store) - 2'(w_deq);
    end
  end
endmodule

// File: rtl/la_ram_write_arbiter.sv
// Round-robin drain of both pods' capture FIFOs into DDR, one full write burst per grant.
module la_ram_write_arbiter
  import la_ram_pkg::*;
#(
  parameter int BURST_LEN  = 4,
  parameter int ADDR_WIDTH = 29
) (
  input  logic                  clk_ram_2x,
  input  logic                  trig_rst_arbiter_2x,
  input  logic                  ram_ready,
  output logic                  la0_ram_addr_rd_en,
  input  logic [ADDR_WIDTH-1:0] la0_ram_addr_rd_data,
  input  logic [7:0]            la0_ram_addr_rd_size,
  output logic                  la0_ram_data_rd_en,
  input  logic [127:0]          la0_ram_data_rd_data,
  input  logic [9:0]            la0_ram_data_rd_size,
  output logic                  la1_ram_addr_rd_en,
  input  logic [ADDR_WIDTH-1:0] la1_ram_addr_rd_data,
  input  logic [7:0]            la1_ram_addr_rd_size,
  output logic                  la1_ram_data_rd_en,
  input  logic [127:0]          la1_ram_data_rd_data,
  input  logic [9:0]            la1_ram_data_rd_size,
  la_ram_write_arbiter_if.master app,
  output logic                  busy,
  output logic [31:0]           la0_burst_count,
  output logic [31:0]           la1_burst_count
);
  localparam logic [7:0] LEN   = 8'(BURST_LEN);
  localparam logic [7:0] LAST  = 8'(BURST_LEN - 1);
  localparam logic [9:0] LEN_D = 10'(BURST_LEN);

  state_t                r_state;
  pod_t                  r_grant;
  logic                  r_prio;
  logic                  r_addr_rd_en0;
  logic                  r_addr_rd_en1;
  logic                  r_app_en;
  logic [ADDR_WIDTH-1:0] r_app_addr;
  logic [7:0]            r_popped;
  logic [7:0]            r_accepted;
  logic                  r_inflight;
  logic                  r_data_done;
  logic [31:0]           r_cnt0;
  logic [31:0]           r_cnt1;

  logic                  w_elig0;
  logic                  w_elig1;
  pod_t                  w_pick;
  logic                  w_pop;
  logic                  w_wacc;
  logic                  w_last_acc;
  logic                  w_skid_valid;
  logic [127:0]          w_skid_data;
  logic [1:0]            w_skid_count;
  logic [127:0]          w_rd_data;
  logic [ADDR_WIDTH-1:0] w_rd_addr;

  assign w_elig0 = ram_ready && (la0_ram_addr_rd_size != '0) && (la0_ram_data_rd_size >= LEN_D);
  assign w_elig1 = ram_ready && (la1_ram_addr_rd_size != '0) && (la1_ram_data_rd_size >= LEN_D);
  assign w_pick  = (w_elig0 && w_elig1) ? r_prio : w_elig1;

  assign w_rd_data = (r_grant == POD1) ? la1_ram_data_rd_data : la0_ram_data_rd_data;
  assign w_rd_addr = (r_grant == POD1) ? la1_ram_addr_rd_data : la0_ram_addr_rd_data;

  // Words in flight from the FIFO count against skid space so a stall never overflows it.
  assign w_pop = ((r_state == ST_CMD) || (r_state == ST_DATA)) &&
                 ((w_skid_count + {1'b0, r_inflight}) < 2'd2) &&
                 (r_popped != LEN);

  assign w_wacc     = w_skid_valid && app.app_wdf_rdy;
  assign w_last_acc = w_wacc && (r_accepted == LAST);

  la_write_skid u_skid (
    .clk       (clk_ram_2x),
    .rst       (trig_rst_arbiter_2x),
    .push      (r_inflight),
    .push_data (w_rd_data),
    .pop_ready (app.app_wdf_rdy),
    .out_valid (w_skid_valid),
    .out_data  (w_skid_data),
    .count     (w_skid_count)
  );

  assign la0_ram_addr_rd_en = r_addr_rd_en0;
  assign la1_ram_addr_rd_en = r_addr_rd_en1;
  assign la0_ram_data_rd_en = w_pop && (r_grant == POD0);
  assign la1_ram_data_rd_en = w_pop && (r_grant == POD1);

  assign app.app_en       = r_app_en;
  assign app.app_cmd      = APP_CMD_WRITE;
  assign app.app_addr     = r_app_addr;
  assign app.app_wdf_data = w_skid_data;
  assign app.app_wdf_wren = w_skid_valid;
  assign app.app_wdf_end  = w_skid_valid && (r_accepted == LAST);

  assign busy            = (r_state != ST_IDLE);
  assign la0_burst_count = r_cnt0;
  assign la1_burst_count = r_cnt1;

  always_ff @(posedge clk_ram_2x) begin
    if (trig_rst_arbiter_2x) begin
      r_state       <= ST_IDLE;
      r_grant       <= POD0;
      r_prio        <= 1'b0;
      r_addr_rd_en0 <= 1'b0;
      r_addr_rd_en1 <= 1'b0;
      r_app_en      <= 1'b0;
      r_app_addr    <= '0;
    end else begin
      r_addr_rd_en0 <= 1'b0;
      r_addr_rd_en1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_elig0 || w_elig1) begin
            r_grant       <= w_pick;
            r_addr_rd_en0 <= (w_pick == POD0);
            r_addr_rd_en1 <= (w_pick == POD1);
            r_state       <= ST_ADDR_POP;
          end
        end
        ST_ADDR_POP: r_state <= ST_ADDR_WAIT;
        ST_ADDR_WAIT: begin
          r_app_addr <= w_rd_addr;
          r_app_en   <= 1'b1;
          r_state    <= ST_CMD;
        end
        ST_CMD: begin
          if (app.app_rdy) begin
            r_app_en <= 1'b0;
            // All data may already have drained ahead of the command.
            if (r_data_done || w_last_acc) begin
              r_prio  <= ~r_grant;
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_last_acc) begin
            r_prio  <= ~r_grant;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_ram_2x) begin
    if (trig_rst_arbiter_2x) begin
      r_popped    <= '0;
      r_accepted  <= '0;
      r_inflight  <= 1'b0;
      r_data_done <= 1'b0;
      r_cnt0      <= '0;
      r_cnt1      <= '0;
    end else begin
      r_inflight <= w_pop;
      if (r_state == ST_IDLE) begin
        r_popped    <= '0;
        r_accepted  <= '0;
        r_data_done <= 1'b0;
      end else begin
        if (w_pop) begin
          r_popped <= r_popped + 8'd1;
        end
        if (w_wacc) begin
          r_accepted <= r_accepted + 8'd1;
        end
        if (w_last_acc) begin
          r_data_done <= 1'b1;
        end
      end
      if (w_last_acc) begin
        if (r_grant == POD1) begin
          r_cnt1 <= r_cnt1 + 32'd1;
        end else begin
          r_cnt0 <= r_cnt0 + 32'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_la_ram_write_arbiter.sv
// Scoreboard bench: FIFO models feed the arbiter, expected bursts are ordered by a round-robin model.
module tb_la_ram_write_arbiter;
  import la_ram_pkg::*;

  localparam int BL = 4;
  localparam int AW = 29;

  typedef struct packed {
    logic              pod;
    logic [AW-1:0]     addr;
    logic [BL*128-1:0] words;
  } burst_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ram_ready = 1'b0;
  logic          l0_aen, l0_den, l1_aen, l1_den;
  logic [AW-1:0] l0_addr = '0;
  logic [AW-1:0] l1_addr = '0;
  logic [7:0]    l0_asz = '0;
  logic [7:0]    l1_asz = '0;
  logic [127:0]  l0_data = '0;
  logic [127:0]  l1_data = '0;
  logic [9:0]    l0_dsz = '0;
  logic [9:0]    l1_dsz = '0;
  logic          busy;
  logic [31:0]   cnt0, cnt1;

  la_ram_write_arbiter_if #(.ADDR_WIDTH(AW)) app();

  la_ram_write_arbiter #(.BURST_LEN(BL), .ADDR_WIDTH(AW)) dut (
    .clk_ram_2x           (clk),
    .trig_rst_arbiter_2x  (rst),
    .ram_ready            (ram_ready),
    .la0_ram_addr_rd_en   (l0_aen),
    .la0_ram_addr_rd_data (l0_addr),
    .la0_ram_addr_rd_size (l0_asz),
    .la0_ram_data_rd_en   (l0_den),
    .la0_ram_data_rd_data (l0_data),
    .la0_ram_data_rd_size (l0_dsz),
    .la1_ram_addr_rd_en   (l1_aen),
    .la1_ram_addr_rd_data (l1_addr),
    .la1_ram_addr_rd_size (l1_asz),
    .la1_ram_data_rd_en   (l1_den),
    .la1_ram_data_rd_data (l1_data),
    .la1_ram_data_rd_size (l1_dsz),
    .app                  (app),
    .busy                 (busy),
    .la0_burst_count      (cnt0),
    .la1_burst_count      (cnt1)
  );

  always #5 clk = ~clk;

  logic [AW-1:0] aq0[$], aq1[$];
  logic [127:0]  dq0[$], dq1[$];
  burst_t        exp_q[$];
  int            n_chk = 0, n_err = 0;
  int            mcnt0 = 0, mcnt1 = 0;
  logic          mprio = 1'b0;
  int            pops0 = 0, rdy_mode = 0, cyc = 0;
  int            t_a = -1, t_e = -1, t_i = -1;
  logic [127:0]  held_word = '0;
  logic          s_a0, s_a1, s_d0, s_d1, s_busy, s_app_en, s_wren, s_end, s_wrdy;
  logic [AW-1:0] s_app_addr;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic update_sizes();
    l0_asz = 8'(aq0.size());
    l1_asz = 8'(aq1.size());
    l0_dsz = 10'(dq0.size());
    l1_dsz = 10'(dq1.size());
  endtask

  // One clock: sample DUT at negedge, then act as the FIFOs and drive ready lines after the edge.
  task automatic cycle();
    @(negedge clk);
    s_a0 = l0_aen; s_a1 = l1_aen; s_d0 = l0_den; s_d1 = l1_den;
    s_busy = busy; s_app_en = app.app_en; s_app_addr = app.app_addr;
    s_wren = app.app_wdf_wren; s_end = app.app_wdf_end; s_wrdy = app.app_wdf_rdy;
    @(posedge clk); #1;
    cyc++;
    if (s_a0) begin
      check("pod0 addr pop nonempty", 128'(aq0.size() != 0), 128'd1);
      if (aq0.size() != 0) l0_addr = aq0.pop_front();
    end
    if (s_a1) begin
      check("pod1 addr pop nonempty", 128'(aq1.size() != 0), 128'd1);
      if (aq1.size() != 0) l1_addr = aq1.pop_front();
    end
    if (s_d0) begin
      pops0++;
      check("pod0 data pop nonempty", 128'(dq0.size() != 0), 128'd1);
      if (dq0.size() != 0) l0_data = dq0.pop_front();
    end
    if (s_d1) begin
      check("pod1 data pop nonempty", 128'(dq1.size() != 0), 128'd1);
      if (dq1.size() != 0) l1_data = dq1.pop_front();
    end
    update_sizes();
    case (rdy_mode)
      1: begin
        app.app_rdy     = ($urandom_range(3) != 0);
        app.app_wdf_rdy = ($urandom_range(3) != 0);
      end
      2: begin
        app.app_rdy     = 1'b1;
        app.app_wdf_rdy = ((cyc % 2) == 0);
      end
      3: begin
        app.app_rdy     = 1'b0;
        app.app_wdf_rdy = 1'b0;
      end
      default: begin
        app.app_rdy     = 1'b1;
        app.app_wdf_rdy = 1'b1;
      end
    endcase
  endtask

  // Fill the pod FIFOs and queue the expected bursts in round-robin grant order.
  task automatic load_batch(input int n0, input int n1, input logic [AW-1:0] base, input bit hold_last);
    burst_t b0[$], b1[$];
    burst_t b;
    logic   pick;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < ((p == 0) ? n0 : n1); k++) begin
        b.pod  = (p == 1);
        b.addr = base + AW'(p * 'h1000 + k * BL);
        for (int w = 0; w < BL; w++)
          b.words[w*128 +: 128] = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (p == 0) begin
          b0.push_back(b); aq0.push_back(b.addr);
          for (int w = 0; w < BL; w++) dq0.push_back(b.words[w*128 +: 128]);
        end else begin
          b1.push_back(b); aq1.push_back(b.addr);
          for (int w = 0; w < BL; w++) dq1.push_back(b.words[w*128 +: 128]);
        end
      end
    end
    if (hold_last) held_word = dq0.pop_back();
    while (b0.size() + b1.size() > 0) begin
      if (b0.size() != 0 && b1.size() != 0) pick = mprio;
      else pick = (b1.size() != 0);
      b = pick ? b1.pop_front() : b0.pop_front();
      exp_q.push_back(b);
      if (pick) mcnt1++; else mcnt0++;
      mprio = ~pick;
    end
    update_sizes();
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < 400) begin
      cycle();
      k++;
    end
    check({name, " drained"}, 128'(k < 400), 128'd1);
    check({name, " la0_burst_count"}, 128'(cnt0), 128'(mcnt0));
    check({name, " la1_burst_count"}, 128'(cnt1), 128'(mcnt1));
    check({name, " fifos emptied"}, 128'(aq0.size() + aq1.size() + dq0.size() + dq1.size()), 128'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " app_en"}, 128'(app.app_en), 128'd0);
    check({tag, " app_cmd"}, 128'(app.app_cmd), 128'd0);
    check({tag, " app_addr"}, 128'(app.app_addr), 128'd0);
    check({tag, " app_wdf_data"}, app.app_wdf_data, 128'd0);
    check({tag, " app_wdf_wren"}, 128'(app.app_wdf_wren), 128'd0);
    check({tag, " app_wdf_end"}, 128'(app.app_wdf_end), 128'd0);
    check({tag, " rd_en strobes"}, 128'({l0_aen, l0_den, l1_aen, l1_den}), 128'd0);
    check({tag, " busy"}, 128'(busy), 128'd0);
    check({tag, " la0_burst_count"}, 128'(cnt0), 128'd0);
    check({tag, " la1_burst_count"}, 128'(cnt1), 128'd0);
  endtask

  // Monitor: compares every accepted command and data word against the head expected burst.
  initial begin : monitor
    int   w;
    logic cmd_ok, prev_a0, prev_a1;
    w = 0; cmd_ok = 1'b0; prev_a0 = 1'b0; prev_a1 = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        w = 0; cmd_ok = 1'b0;
      end else begin
        if (l0_aen || l0_den || l1_aen || l1_den) begin
          check("pop with burst pending", 128'(exp_q.size() != 0), 128'd1);
          if (exp_q.size() != 0) begin
            if (l0_aen || l0_den) check("pod0 pop grant", 128'(exp_q[0].pod), 128'd0);
            if (l1_aen || l1_den) check("pod1 pop grant", 128'(exp_q[0].pod), 128'd1);
          end
        end
        if (l0_aen) check("pod0 addr strobe single-cycle", 128'(prev_a0), 128'd0);
        if (l1_aen) check("pod1 addr strobe single-cycle", 128'(prev_a1), 128'd0);
        if (app.app_en && app.app_rdy) begin
          check("app_cmd write", 128'(app.app_cmd), 128'(APP_CMD_WRITE));
          check("cmd with burst pending", 128'(exp_q.size() != 0), 128'd1);
          if (exp_q.size() != 0) check("app_addr", 128'(app.app_addr), 128'(exp_q[0].addr));
          cmd_ok = 1'b1;
        end
        if (app.app_wdf_wren && app.app_wdf_rdy) begin
          check("word with burst pending", 128'(exp_q.size() != 0 && w < BL), 128'd1);
          if (exp_q.size() != 0 && w < BL) begin
            check("app_wdf_data", app.app_wdf_data, exp_q[0].words[w*128 +: 128]);
            check("app_wdf_end", 128'(app.app_wdf_end), 128'(w == BL - 1));
            w++;
          end
        end
        if (cmd_ok && w == BL) begin
          void'(exp_q.pop_front());
          w = 0; cmd_ok = 1'b0;
        end
      end
      prev_a0 = l0_aen; prev_a1 = l1_aen;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int   k, acc;
    logic seen;
    app.app_rdy = 1'b1;
    app.app_wdf_rdy = 1'b1;
    repeat (3) cycle();
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    ram_ready = 1'b1;

    // Both pods loaded: strict alternation starting from pod 0.
    load_batch(3, 3, AW'($urandom()), 1'b0);
    drain("round robin");

    // Single burst, minimum latency.
    load_batch(1, 0, AW'('h100), 1'b0);
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (s_a0 && t_a < 0) t_a = c;
      if (s_wren && s_end && t_e < 0) t_e = c;
      if (t_a >= 0 && !s_busy && t_i < 0) t_i = c;
    end
    check("addr_rd_en cycle", 128'(t_a), 128'd1);
    check("wdf_end cycle", 128'(t_e), 128'(3 + BL));
    check("return to idle cycle", 128'(t_i), 128'(4 + BL));
    drain("single pod");

    // app_wdf_rdy alternating.
    rdy_mode = 2; pops0 = 0;
    load_batch(1, 0, AW'($urandom()), 1'b0);
    drain("wdf toggle");
    check("wdf toggle pop count", 128'(pops0), 128'(BL));

    // Command and data channel stalled.
    rdy_mode = 3; pops0 = 0;
    load_batch(1, 0, AW'('h2000), 1'b0);
    k = 0;
    while (!s_app_en && k < 10) begin cycle(); k++; end
    check("stall cmd reached", 128'(s_app_en), 128'd1);
    for (int c = 0; c < 10; c++) begin
      cycle();
      check("stall app_en held", 128'(s_app_en), 128'd1);
      check("stall app_addr held", 128'(s_app_addr), 128'(AW'('h2000)));
    end
    check("stall pops halted", 128'(pops0), 128'd2);
    rdy_mode = 0;
    drain("cmd stall");
    check("stall total pops", 128'(pops0), 128'(BL));

    // One data word short of a burst: no grant until it arrives.
    load_batch(1, 0, AW'($urandom()), 1'b1);
    seen = 1'b0;
    repeat (20) begin cycle(); if (s_busy || s_a0) seen = 1'b1; end
    check("short data no grant", 128'(seen), 128'd0);
    dq0.push_back(held_word);
    update_sizes();
    drain("short data");

    // Controller not ready: no grant; dropping ready mid-burst does not abort.
    ram_ready = 1'b0;
    load_batch(0, 1, AW'($urandom()), 1'b0);
    seen = 1'b0;
    repeat (15) begin cycle(); if (s_busy || s_a1) seen = 1'b1; end
    check("ram_ready low no grant", 128'(seen), 128'd0);
    ram_ready = 1'b1;
    k = 0;
    while (!s_busy && k < 10) begin cycle(); k++; end
    check("ram_ready high grant", 128'(s_busy), 128'd1);
    repeat (2) cycle();
    ram_ready = 1'b0;
    drain("ram_ready drop");
    ram_ready = 1'b1;

    // Randomized batches with random back-pressure.
    rdy_mode = 1;
    for (int b = 0; b < 8; b++) begin
      load_batch($urandom_range(3), $urandom_range(3), AW'($urandom()), 1'b0);
      drain("random");
    end

    // Reset mid-burst with prio pointing at pod 1 beforehand.
    rdy_mode = 0;
    load_batch(1, 0, AW'($urandom()), 1'b0);
    drain("pre-reset");
    load_batch(0, 1, AW'($urandom()), 1'b0);
    acc = 0; k = 0;
    while (acc < 2 && k < 40) begin
      cycle(); k++;
      if (s_wren && s_wrdy) acc++;
    end
    check("two words before reset", 128'(acc), 128'd2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    aq0.delete(); aq1.delete(); dq0.delete(); dq1.delete();
    update_sizes();
    mcnt0 = 0; mcnt1 = 0; mprio = 1'b0;
    @(negedge clk);
    check_zero("mid-burst reset");
    @(posedge clk); #1;
    load_batch(1, 1, AW'($urandom()), 1'b0);
    drain("post-reset prio");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
